// File: rtl/ones_accumulator.sv
// rtl/ones_accumulator.sv - sums per-word ones counts over a frame of frame_p words
//
// Purpose: accumulates upstream ones counts (count_i) across frame_p accepted words
// and hands the frame total to a downstream consumer with a valid/ready handshake.
// Optional build macro: ACCUM_SATURATE_EN clamps the accumulator at 2^sum_width_p-1
// once it overflows; without it the accumulator wraps. overflow_o is reported in both.
//
// Ports:
//   clk_i       in   1                    clock, rising edge
//   reset_n_i   in   1                    asynchronous active-low reset
//   count_i     in   $clog2(width_p)+1    ones count of one word
//   valid_i     in   1                    count_i valid
//   ready_o     out  1                    block accepts count_i (ACCUM state)
//   sum_o       out  sum_width_p          frame total
//   overflow_o  out  1                    frame total exceeded sum_width_p, qualified by valid_o
//   valid_o     out  1                    sum_o/overflow_o valid (DONE state)
//   ready_i     in   1                    downstream accepts sum_o

module ones_accumulator #(
    parameter int width_p     = 32,
    parameter int frame_p     = 8,
    parameter int sum_width_p = 9,
    localparam int count_width_lp = $clog2(width_p) + 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [count_width_lp-1:0] count_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [sum_width_p-1:0]    sum_o,
    output logic                      overflow_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

    localparam int cnt_width_lp = (frame_p > 1) ? $clog2(frame_p) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [sum_width_p-1:0]   acc_q;
    logic [cnt_width_lp-1:0]  cnt_q;
    logic                     ovf_q;

    logic [sum_width_p:0]     sum_ext;
    logic                     carry;
    logic [sum_width_p-1:0]   acc_next;
    logic                     ovf_next;
    logic                     last_word;
    logic                     accept;
    logic                     handoff;

    // One extra bit on the adder exposes the carry out of the sum_width_p range.
    assign sum_ext   = {1'b0, acc_q} + {{(sum_width_p + 1 - count_width_lp){1'b0}}, count_i};
    assign carry     = sum_ext[sum_width_p];
    assign ovf_next  = ovf_q | carry;
    assign last_word = (cnt_q == cnt_width_lp'(frame_p - 1));
    assign accept    = valid_i & ready_o;
    assign handoff   = valid_o & ready_i;

`ifdef ACCUM_SATURATE_EN
    // Once saturated the accumulator stays pinned for the rest of the frame,
    // even though later additions of small counts would not carry on their own.
    assign acc_next = ovf_next ? {sum_width_p{1'b1}} : sum_ext[sum_width_p-1:0];
`else
    assign acc_next = sum_ext[sum_width_p-1:0];
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            ACCUM: begin
                ready_o = 1'b1;
                if (valid_i && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            sum_o      <= '0;
            overflow_o <= 1'b0;
        end else if (handoff) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + cnt_width_lp'(1);
            ovf_q <= ovf_next;
            if (last_word) begin
                sum_o      <= acc_next;
                overflow_o <= ovf_next;
            end
        end
    end

endmodule

// File: doc/ones_accumulator.md
ONES_ACCUMULATOR -- requirements
Module: ones_accumulator

Interface
REQ-001 SHALL have parameter width_p, default 32, bit width of the word whose ones were counted upstream.
REQ-002 SHALL have parameter frame_p, default 8, words per frame; legal range 1..255.
REQ-003 SHALL have parameter sum_width_p, default 9, frame sum width; legal range >= $clog2(width_p)+1.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port count_i  input  $clog2(width_p)+1  ones count of one word.
REQ-007 SHALL have port valid_i  input  1  count_i valid.
REQ-008 SHALL have port ready_o  output  1  block accepts count_i.
REQ-009 SHALL have port sum_o  output  sum_width_p  frame total.
REQ-010 SHALL have port overflow_o  output  1  frame total exceeded sum_width_p range; qualified by valid_o.
REQ-011 SHALL have port valid_o  output  1  sum_o/overflow_o valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts sum_o.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM, DONE.
REQ-014 SHALL drive ready_o=1, valid_o=0 in ACCUM; ready_o=0, valid_o=1 in DONE.
REQ-015 SHALL accept a word only on a clk_i edge with valid_i & ready_o; no other edge changes the accumulator or word counter.
REQ-016 SHALL, on each accepted word, add count_i (zero-extended) to the accumulator and increment the word counter.
REQ-017 SHALL, on accepting word index frame_p-1, load sum_o with accumulator+count_i and go to DONE; sum_o valid the following cycle.
REQ-018 SHALL, with frame_p=1, enter DONE after each single accepted word.
REQ-019 SHALL hold sum_o, overflow_o and valid_o stable in DONE until valid_o & ready_i.
REQ-020 SHALL, on valid_o & ready_i, return to ACCUM with accumulator, word counter and overflow cleared; no word accepted that edge (ready_o=0).
REQ-021 SHALL sustain one frame per frame_p+1 cycles when valid_i and ready_i are held high.
REQ-022 SHALL set overflow for the frame if any addition carries out of sum_width_p bits; sticky until frame handed off.
REQ-023 SHALL treat count_i > width_p as legal data (no clamping); behaviour per REQ-016/022.
REQ-024 SHALL ignore count_i when valid_i=0, including X values.

Reset
REQ-025 SHALL, while reset_n_i=0, asynchronously force state ACCUM, accumulator 0, word counter 0, sum_o 0, overflow_o 0, valid_o 0; ready_o becomes 1 per REQ-014.
REQ-026 SHALL discard a partial frame or unaccepted sum when reset asserts mid-operation; first frame after release starts at word 0.
REQ-027 SHALL leave reset synchronously-safe: first acceptance no earlier than the first rising edge after reset_n_i deasserts.

Configuration
REQ-028 SHALL, with ACCUM_SATURATE_EN defined, clamp accumulator at 2^sum_width_p-1 on overflow and hold it there for the rest of the frame.
REQ-029 SHALL, without ACCUM_SATURATE_EN, wrap accumulator modulo 2^sum_width_p; overflow_o per REQ-022 in both builds.

Verification
REQ-030 SHALL cover: reset, then 8 words count_i=32, ready_i=1 -> valid_o high one cycle after 8th accept, sum_o=256, overflow_o=0.
REQ-031 SHALL cover: 8 words count_i=1,2,3,4,5,6,7,8 with valid_i toggled every other cycle -> sum_o=36, only valid-high edges counted.
REQ-032 SHALL cover: sum_width_p=8, 8 words count_i=32 -> overflow_o=1; sum_o=0 without ACCUM_SATURATE_EN, sum_o=255 with it.
REQ-033 SHALL cover: frame complete, ready_i=0 for 5 cycles while valid_i=1 -> ready_o=0, sum_o stable; ready_i=1 -> next frame starts at 0.
REQ-034 SHALL cover: reset_n_i pulsed low after 3 of 8 words -> outputs per REQ-025 immediately; next 8 words count_i=2 give sum_o=16.
REQ-035 SHALL cover: frame_p=1, valid_i and ready_i held high, count_i=5 -> valid_o every other cycle, sum_o=5 each frame.
